// File: rtl/rx232_pkg.sv
// Shared definitions for the RS232 frame parser: FSM states, error codes
// and the default start-of-frame marker.
package rx232_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LEN,
        ST_DATA,
        ST_CHK,
        ST_HOLD
    } state_t;

    localparam logic [1:0] ERR_LEN = 2'd1;
    localparam logic [1:0] ERR_CHK = 2'd2;
    localparam logic [1:0] ERR_TMO = 2'd3;

    localparam logic [7:0] DEF_SOF_BYTE = 8'h02;

endpackage

// File: rtl/rx232_frame_parser_if.sv
// Byte input, buffer read port and packet status bundle of the frame parser.
// The master side is the receiver/host; the slave side is the parser.
interface rx232_frame_parser_if #(
    parameter int MAX_LEN = 16
);
    localparam int AW = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;

    logic [7:0]    rxpd;
    logic          rxen;
    logic [AW-1:0] rd_addr;
    logic [7:0]    rd_data;
    logic          pkt_valid;
    logic [7:0]    pkt_len;
    logic          pkt_ack;
    logic          pkt_err;
    logic [1:0]    err_code;
    logic          drop_flag;

    modport master (
        output rxpd, rxen, rd_addr, pkt_ack,
        input  rd_data, pkt_valid, pkt_len, pkt_err, err_code, drop_flag
    );

    modport slave (
        input  rxpd, rxen, rd_addr, pkt_ack,
        output rd_data, pkt_valid, pkt_len, pkt_err, err_code, drop_flag
    );

endinterface

// File: rtl/rx232_rise_det.sv
// One-flop rising-edge detector: turns a level into a single-cycle strobe.
module rx232_rise_det (
    input  logic clk,
    input  logic rst,
    input  logic d_i,
    output logic rise_o
);

    logic d_q;

    // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) d_q <= 1'b0;
        else      d_q <= d_i;
    end

    assign rise_o = d_i & ~d_q;

endmodule

// File: rtl/rx232_frame_parser.sv
// Assembles SOF/LEN/payload/CHK frames from received bytes, validates them
// and holds the payload in a readable buffer until the host acknowledges.
module rx232_frame_parser
    import rx232_pkg::*;
#(
    parameter int         MAX_LEN     = 16,
    parameter logic [7:0] SOF_BYTE    = DEF_SOF_BYTE,
    parameter int         TIMEOUT_CYC = 100000
) (
    input logic                 clk,
    input logic                 rst,
    rx232_frame_parser_if.slave bus
);

    localparam int AW = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
    localparam int IW = $clog2(MAX_LEN) + 1;
    localparam int TW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;

    localparam logic [7:0]    MAX_LEN_B = 8'(MAX_LEN);
    localparam logic [AW:0]   DEPTH_A   = (AW + 1)'(MAX_LEN);
    localparam logic [TW-1:0] TMO_LAST  = TW'(TIMEOUT_CYC - 1);

    state_t        state_q, state_d;
    logic [7:0]    len_q, len_d;
    logic [7:0]    chk_q, chk_d;
    logic [IW-1:0] idx_q, idx_d;
    logic [TW-1:0] tmo_q, tmo_d;
    logic          pkt_valid_q, pkt_valid_d;
    logic [7:0]    pkt_len_q, pkt_len_d;
    logic          pkt_err_q, pkt_err_d;
    logic [1:0]    err_code_q, err_code_d;
    logic          drop_q, drop_d;
    logic [7:0]    rd_data_q;
    logic [7:0]    buf_q [MAX_LEN];

    logic byte_stb;
    logic wr_en;
    logic tmo_hit;

    rx232_rise_det u_rxen_det (
        .clk    (clk),
        .rst    (rst),
        .d_i    (bus.rxen),
        .rise_o (byte_stb)
    );

    // A byte arriving in the expiry cycle wins over the timeout.
    assign tmo_hit = (state_q inside {ST_LEN, ST_DATA, ST_CHK}) &&
                     (tmo_q == TMO_LAST) && !byte_stb;

    // NOTE: every always_comb output gets a default first, so no path infers a latch.
    always_comb begin
        state_d     = state_q;
        len_d       = len_q;
        chk_d       = chk_q;
        idx_d       = idx_q;
        pkt_valid_d = pkt_valid_q;
        pkt_len_d   = pkt_len_q;
        pkt_err_d   = 1'b0;
        err_code_d  = err_code_q;
        drop_d      = drop_q;
        wr_en       = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (byte_stb && bus.rxpd == SOF_BYTE) state_d = ST_LEN;
            end
            ST_LEN: begin
                if (byte_stb) begin
                    if (bus.rxpd == 8'd0 || bus.rxpd > MAX_LEN_B) begin
                        pkt_err_d  = 1'b1;
                        err_code_d = ERR_LEN;
                        state_d    = ST_IDLE;
                    end else begin
                        len_d   = bus.rxpd;
                        chk_d   = bus.rxpd;
                        idx_d   = '0;
                        state_d = ST_DATA;
                    end
                end
            end
            ST_DATA: begin
                if (byte_stb) begin
                    wr_en = 1'b1;
                    chk_d = chk_q ^ bus.rxpd;
                    idx_d = idx_q + IW'(1);
                    if (idx_q == IW'(len_q - 8'd1)) state_d = ST_CHK;
                end
            end
            ST_CHK: begin
                if (byte_stb) begin
                    if (bus.rxpd == chk_q) begin
                        pkt_valid_d = 1'b1;
                        pkt_len_d   = len_q;
                        state_d     = ST_HOLD;
                    end else begin
                        pkt_err_d  = 1'b1;
                        err_code_d = ERR_CHK;
                        state_d    = ST_IDLE;
                    end
                end
            end
            ST_HOLD: begin
                if (bus.pkt_ack) begin
                    pkt_valid_d = 1'b0;
                    drop_d      = 1'b0;
                    state_d     = ST_IDLE;
                end
                if (byte_stb) drop_d = 1'b1;
            end
            default: state_d = ST_IDLE;
        endcase

        if (tmo_hit) begin
            pkt_err_d  = 1'b1;
            err_code_d = ERR_TMO;
            state_d    = ST_IDLE;
        end

        if (byte_stb || state_d == ST_IDLE || state_d == ST_HOLD) tmo_d = '0;
        else                                                      tmo_d = tmo_q + TW'(1);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= ST_IDLE;
            len_q       <= '0;
            chk_q       <= '0;
            idx_q       <= '0;
            tmo_q       <= '0;
            pkt_valid_q <= 1'b0;
            pkt_len_q   <= '0;
            pkt_err_q   <= 1'b0;
            err_code_q  <= '0;
            drop_q      <= 1'b0;
            rd_data_q   <= '0;
        end else begin
            state_q     <= state_d;
            len_q       <= len_d;
            chk_q       <= chk_d;
            idx_q       <= idx_d;
            tmo_q       <= tmo_d;
            pkt_valid_q <= pkt_valid_d;
            pkt_len_q   <= pkt_len_d;
            pkt_err_q   <= pkt_err_d;
            err_code_q  <= err_code_d;
            drop_q      <= drop_d;
            rd_data_q   <= ({1'b0, bus.rd_addr} < DEPTH_A) ? buf_q[bus.rd_addr] : 8'h00;
        end
    end

    // NOTE: the payload array has no reset; its contents are don't-care until written.
    always_ff @(posedge clk) begin
        if (wr_en) buf_q[AW'(idx_q)] <= bus.rxpd;
    end

    assign bus.rd_data   = rd_data_q;
    assign bus.pkt_valid = pkt_valid_q;
    assign bus.pkt_len   = pkt_len_q;
    assign bus.pkt_err   = pkt_err_q;
    assign bus.err_code  = err_code_q;
    assign bus.drop_flag = drop_q;

endmodule

// File: tb/tb_rx232_frame_parser.sv
// Self-checking bench for rx232_frame_parser: directed scenarios plus random
// frames, checked against a queue-based frame model.
module tb_rx232_frame_parser;

    localparam int         MAX_LEN = 16;
    localparam int         TMO     = 50;
    localparam logic [7:0] SOF     = 8'h02;

    typedef logic [7:0] bq_t [$];

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    rx232_frame_parser_if #(.MAX_LEN(MAX_LEN)) bus ();

    rx232_frame_parser #(
        .MAX_LEN     (MAX_LEN),
        .SOF_BYTE    (SOF),
        .TIMEOUT_CYC (TMO)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int total = 0;
    int bad   = 0;

    // Model: bytes of the frame in progress, plus the held-packet view.
    int frm [$];
    int m_pay [$];
    bit m_hold = 1'b0;
    bit m_drop = 1'b0;
    int m_len  = 0;
    bit e_err;
    int e_code;

    function automatic void model_reset();
        frm.delete();
        m_pay.delete();
        m_hold = 1'b0;
        m_drop = 1'b0;
        m_len  = 0;
    endfunction

    function automatic void model_byte(input logic [7:0] b);
        int x;
        e_err  = 1'b0;
        e_code = 0;
        if (m_hold) begin
            m_drop = 1'b1;
            return;
        end
        if (frm.size() == 0) begin
            if (b == SOF) frm.push_back(int'(b));
            return;
        end
        frm.push_back(int'(b));
        if (frm.size() == 2 && (b == 8'd0 || int'(b) > MAX_LEN)) begin
            e_err = 1'b1; e_code = 1; frm.delete();
            return;
        end
        if (frm.size() == frm[1] + 3) begin
            x = 0;
            for (int i = 1; i < frm.size() - 1; i++) x = x ^ frm[i];
            if (x == int'(b)) begin
                m_hold = 1'b1;
                m_len  = frm[1];
                m_pay.delete();
                for (int i = 2; i < frm.size() - 1; i++) m_pay.push_back(frm[i]);
            end else begin
                e_err = 1'b1; e_code = 2;
            end
            frm.delete();
        end
    endfunction

    function automatic bq_t build_good(input int len);
        bq_t q;
        logic [7:0] x, d;
        x = 8'(len);
        q.push_back(SOF);
        q.push_back(8'(len));
        for (int i = 0; i < len; i++) begin
            d = 8'($urandom);
            q.push_back(d);
            x = x ^ d;
        end
        q.push_back(x);
        return q;
    endfunction

    // rxen high for hi (>=2) cycles, then low for lo cycles; checks at the strobe edge.
    task automatic send_byte(input logic [7:0] b, input int hi, input int lo);
        @(negedge clk);
        bus.rxpd = b;
        bus.rxen = 1'b1;
        @(posedge clk); #1;
        model_byte(b);
        total++;
        if (bus.pkt_err !== e_err) begin
            bad++; $display("FAIL pkt_err after byte %02h: got %b want %b", b, bus.pkt_err, e_err);
        end
        if (e_err) begin
            total++;
            if (bus.err_code !== 2'(e_code)) begin
                bad++; $display("FAIL err_code after byte %02h: got %0d want %0d", b, bus.err_code, e_code);
            end
        end
        total++;
        if (bus.pkt_valid !== m_hold) begin
            bad++; $display("FAIL pkt_valid after byte %02h: got %b want %b", b, bus.pkt_valid, m_hold);
        end
        if (m_hold) begin
            total++;
            if (bus.pkt_len !== 8'(m_len)) begin
                bad++; $display("FAIL pkt_len: got %0d want %0d", bus.pkt_len, m_len);
            end
        end
        total++;
        if (bus.drop_flag !== m_drop) begin
            bad++; $display("FAIL drop_flag after byte %02h: got %b want %b", b, bus.drop_flag, m_drop);
        end
        @(posedge clk); #1;
        total++;
        if (bus.pkt_err !== 1'b0) begin
            bad++; $display("FAIL pkt_err width: got %b want 0 one cycle later", bus.pkt_err);
        end
        repeat (hi - 2) @(posedge clk);
        @(negedge clk);
        bus.rxen = 1'b0;
        repeat (lo) @(negedge clk);
    endtask

    task automatic send_frame(input bq_t fr);
        foreach (fr[i]) send_byte(fr[i], $urandom_range(2, 4), $urandom_range(1, 3));
    endtask

    task automatic check_payload();
        for (int i = 0; i < m_len; i++) begin
            @(negedge clk);
            bus.rd_addr = 4'(i);
            @(posedge clk); #1;
            total++;
            if (bus.rd_data !== 8'(m_pay[i])) begin
                bad++; $display("FAIL rd_data[%0d]: got %02h want %02h", i, bus.rd_data, m_pay[i]);
            end
        end
    endtask

    task automatic do_ack();
        @(negedge clk);
        bus.pkt_ack = 1'b1;
        @(posedge clk); #1;
        m_hold = 1'b0;
        m_drop = 1'b0;
        total++;
        if (bus.pkt_valid !== 1'b0 || bus.drop_flag !== 1'b0) begin
            bad++; $display("FAIL ack release: got valid=%b drop=%b want 0/0", bus.pkt_valid, bus.drop_flag);
        end
        @(negedge clk);
        bus.pkt_ack = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        #1;
        total++;
        if ({bus.rd_data, bus.pkt_valid, bus.pkt_len, bus.pkt_err, bus.err_code, bus.drop_flag} !== 21'd0) begin
            bad++;
            $display("FAIL reset outputs: got rd=%02h v=%b len=%0d err=%b code=%0d drop=%b want all 0",
                     bus.rd_data, bus.pkt_valid, bus.pkt_len, bus.pkt_err, bus.err_code, bus.drop_flag);
        end
        repeat (3) @(negedge clk);
        rst = 1'b1;
        model_reset();
        repeat (2) @(negedge clk);
    endtask

    task automatic test_good_frame();
        bq_t fr = '{8'h02, 8'h03, 8'h11, 8'h22, 8'h33, 8'h03};
        send_frame(fr);
        total++;
        if (bus.pkt_valid !== 1'b1 || bus.pkt_len !== 8'd3) begin
            bad++; $display("FAIL good frame: got valid=%b len=%0d want 1/3", bus.pkt_valid, bus.pkt_len);
        end
        check_payload();
        do_ack();
    endtask

    task automatic test_bad_checksum();
        bq_t fr = '{8'h55, 8'hAA, 8'h02, 8'h02, 8'hAA, 8'h55, 8'h00};
        send_frame(fr);
        total++;
        if (bus.err_code !== 2'd2 || bus.pkt_valid !== 1'b0) begin
            bad++; $display("FAIL bad checksum: got code=%0d valid=%b want 2/0", bus.err_code, bus.pkt_valid);
        end
    endtask

    task automatic test_bad_length();
        bq_t fr = '{8'h02, 8'h00, 8'h02, 8'h11};
        send_frame(fr);
        total++;
        if (bus.err_code !== 2'd1) begin
            bad++; $display("FAIL bad length: got code=%0d want 1", bus.err_code);
        end
    endtask

    task automatic test_timeout();
        int k;
        bq_t fr;
        send_byte(SOF, 2, 2);
        send_byte(8'h04, 2, 2);
        @(negedge clk);
        bus.rxpd = 8'h01;
        bus.rxen = 1'b1;
        @(posedge clk);
        model_byte(8'h01);
        k = 0;
        for (int i = 1; i <= 200 && k == 0; i++) begin
            @(posedge clk); #1;
            if (bus.pkt_err === 1'b1) k = i;
        end
        frm.delete();
        total++;
        if (k != TMO || bus.err_code !== 2'd3) begin
            bad++; $display("FAIL timeout: got delay=%0d code=%0d want %0d/3", k, bus.err_code, TMO);
        end
        @(negedge clk);
        bus.rxen = 1'b0;
        fr = build_good(5);
        send_frame(fr);
        total++;
        if (bus.pkt_valid !== 1'b1) begin
            bad++; $display("FAIL frame after timeout: got valid=%b want 1", bus.pkt_valid);
        end
        check_payload();
        do_ack();
    endtask

    task automatic test_hold_overrun();
        bq_t fr = build_good(MAX_LEN);
        send_frame(fr);
        send_byte(SOF, 2, 2);
        total++;
        if (bus.drop_flag !== 1'b1 || bus.pkt_valid !== 1'b1) begin
            bad++; $display("FAIL overrun: got drop=%b valid=%b want 1/1", bus.drop_flag, bus.pkt_valid);
        end
        check_payload();
        do_ack();
    endtask

    task automatic test_long_rxen();
        bq_t fr = '{8'h02, 8'h01, 8'h7E, 8'h7F};
        foreach (fr[i]) send_byte(fr[i], 40, 3);
        total++;
        if (bus.pkt_valid !== 1'b1 || bus.pkt_len !== 8'd1) begin
            bad++; $display("FAIL long rxen: got valid=%b len=%0d want 1/1", bus.pkt_valid, bus.pkt_len);
        end
        check_payload();
        do_ack();
    endtask

    task automatic test_reset_mid_frame();
        bq_t fr = '{8'h02, 8'h00, 8'h02, 8'h05, 8'hAA, 8'hBB};
        bus.rd_addr = '0;
        send_frame(fr);
        total++;
        if (bus.rd_data !== 8'hAA || bus.err_code !== 2'd1) begin
            bad++; $display("FAIL pre-reset state: got rd=%02h code=%0d want AA/1", bus.rd_data, bus.err_code);
        end
        @(posedge clk); #3;
        rst = 1'b0;
        #1;
        total++;
        if ({bus.rd_data, bus.pkt_valid, bus.pkt_len, bus.pkt_err, bus.err_code, bus.drop_flag} !== 21'd0) begin
            bad++;
            $display("FAIL async reset: got rd=%02h v=%b len=%0d code=%0d drop=%b want all 0",
                     bus.rd_data, bus.pkt_valid, bus.pkt_len, bus.err_code, bus.drop_flag);
        end
        @(negedge clk);
        rst = 1'b1;
        model_reset();
        fr = build_good(2);
        send_frame(fr);
        check_payload();
        do_ack();
    endtask

    task automatic test_random();
        bq_t fr;
        int kind;
        for (int n = 0; n < 30; n++) begin
            kind = $urandom_range(0, 3);
            fr = build_good($urandom_range(1, MAX_LEN));
            case (kind)
                1: fr[fr.size()-1] = fr[fr.size()-1] ^ 8'(1 << $urandom_range(0, 7));
                2: fr[1] = ($urandom_range(0, 1) == 0) ? 8'h00 : 8'($urandom_range(MAX_LEN + 1, 255));
                3: fr.push_front(8'($urandom_range(3, 255)));
                default: ;
            endcase
            send_frame(fr);
            if (m_hold) begin
                check_payload();
                if ($urandom_range(0, 1) == 1) send_byte(8'($urandom), 2, 2);
                do_ack();
            end
        end
    endtask

    initial begin
        bus.rxpd    = '0;
        bus.rxen    = 1'b0;
        bus.rd_addr = '0;
        bus.pkt_ack = 1'b0;
        test_reset();
        test_good_frame();
        test_bad_checksum();
        test_bad_length();
        test_timeout();
        test_hold_overrun();
        test_long_rxen();
        test_reset_mid_frame();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/rx232_frame_parser.md
Name: rx232_frame_parser

Overview:
- Downstream consumer of the RS232 byte receiver. Takes the received byte (rxpd) and its "byte available" level (rxen).
- Assembles framed packets of the form SOF, LEN, payload[LEN], CHK.
- Validates each frame and holds the payload in an internal buffer until the host acknowledges it.
- Reports framing, checksum and inter-byte timeout errors.

Parameters:
- MAX_LEN, 16, maximum payload bytes per frame (legal range 1..255); also sets the buffer depth.
- SOF_BYTE, 8'h02, start-of-frame marker.
- TIMEOUT_CYC, 100000, clk cycles allowed between consecutive bytes inside a frame.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-low reset
- rxpd  in  8  received byte from the receiver; stable whenever rxen=1
- rxen  in  1  receiver byte-available level; each 0->1 transition marks exactly one new byte
- rd_addr  in  $clog2(MAX_LEN)  payload buffer read index
- rd_data  out  8  payload byte at rd_addr, registered, 1-cycle read latency
- pkt_valid  out  1  a complete, checked frame is held
- pkt_len  out  8  payload length of the held frame
- pkt_ack  in  1  host releases the held frame
- pkt_err  out  1  one-cycle error pulse
- err_code  out  2  error cause, valid with pkt_err: 1 = bad LEN, 2 = checksum mismatch, 3 = timeout
- drop_flag  out  1  sticky: a byte arrived while a frame was held and was discarded

Behaviour:
- Byte strobe: rxen registered once into rxen_d; byte_stb = rxen & ~rxen_d; rxpd is sampled in the byte_stb cycle.
- Reset values: rd_data=0, pkt_valid=0, pkt_len=0, pkt_err=0, err_code=0, drop_flag=0, FSM=IDLE, checksum=0, byte index=0, timeout counter=0.
- Reset mid-frame: discards partial data immediately; buffer contents become don't-care.
- FSM states:
  - IDLE: on byte_stb with rxpd==SOF_BYTE go to LEN; any other byte is ignored.
  - LEN: on byte_stb, if rxpd is 0 or greater than MAX_LEN, pulse pkt_err with code 1 and go to IDLE. Otherwise latch len=rxpd, chk=rxpd, idx=0 and go to DATA.
  - DATA: on byte_stb write buf[idx]=rxpd, set chk ^= rxpd, idx++. When idx reaches len-1 on a write, go to CHK.
  - CHK: on byte_stb, if rxpd==chk set pkt_valid=1 and pkt_len=len the next cycle and go to HOLD. Otherwise pulse pkt_err with code 2 and go to IDLE.
  - HOLD: pkt_valid stays 1 and the buffer is frozen. On pkt_ack: pkt_valid=0, drop_flag=0, go to IDLE. A byte_stb in HOLD (including one coinciding with pkt_ack) sets drop_flag and is discarded.
- A SOF_BYTE value seen inside LEN/DATA/CHK is treated as ordinary data; there is no resync.
- Timeout: the counter clears on every byte_stb and on entry to IDLE, and counts in LEN/DATA/CHK. On reaching TIMEOUT_CYC-1: pulse pkt_err with code 3, go to IDLE. If byte_stb occurs in that same cycle, the byte takes priority and no timeout fires.
- pkt_err is high for exactly 1 cycle. err_code holds its last value until the next error.
- Latency: pkt_valid rises 1 clk after the CHK byte_stb.
- Buffer reads: rd_data = buf[rd_addr] registered every cycle. Reading an address >= pkt_len returns stale data, which is legal.
- Width rules: chk is 8-bit XOR; idx uses $clog2(MAX_LEN)+1 bits, so there is no wrap for MAX_LEN=255.

Decomposition:
- Shared package rx232_pkg holds:
  - FSM state enum (IDLE, LEN, DATA, CHK, HOLD)
  - ERR_LEN, ERR_CHK and ERR_TMO constants
  - default SOF_BYTE
- One sub-module, rx232_rise_det: 1-bit register plus rising-edge pulse, reused for rxen.
- The buffer is inline register-array logic, not a separate module.

Test Plan:
- Good frame: bytes 02,03,11,22,33, CHK=03^11^22^33=03 -> pkt_valid=1, pkt_len=3; reads at addresses 0..2 return 11,22,33; after pkt_ack, pkt_valid=0.
- Bad checksum: 02,02,AA,55, CHK=00 (correct value is FD) -> pkt_err pulse, err_code=2, pkt_valid stays 0, FSM back in IDLE.
- Bad length: 02,00 -> err_code=1. Also 02 followed by a LEN of 17 with MAX_LEN=16 -> err_code=1. Leading junk bytes 55,AA before SOF are ignored.
- Timeout with TIMEOUT_CYC=50: 02,04,01, then silence -> err_code=3 exactly 50 clks after the last byte_stb. A following good frame is accepted normally.
- Hold overrun: deliver a good frame, withhold pkt_ack, send byte 02 -> drop_flag=1, buffer unchanged; pkt_ack clears both pkt_valid and drop_flag.
- rxen held high for 10 baud periods yields exactly one byte. Asserting rst in DATA state returns all outputs to reset values asynchronously.
